// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xdata_t;

   // Clear engine states
   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_t;

endpackage

// File: rtl/regfile_mp_read_port.sv
// One read port: array lookup, register-0 masking and write-to-read bypass.
module rf_read_port #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned NWR      = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned AW       = $clog2(NREGS)
) (
   input  logic [AW-1:0]       addr,
   input  logic [XLEN-1:0]     regs [NREGS],
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                byp_en,
   output logic [XLEN-1:0]     data,
   output logic                hit
);

   logic is_zero;

   assign is_zero = (ZERO_REG != 0) && (addr == '0);

   // Raw lookup, then later write ports override earlier ones so the highest index wins
   always_comb begin
      data = is_zero ? '0 : regs[addr];
      hit  = 1'b0;
      if (byp_en && !is_zero) begin
         for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
               data = wr_data[j*XLEN +: XLEN];
               hit  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with bypass, pending-write scoreboard and sequenced clear.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NRD*$clog2(NREGS)-1:0]         rd_addr,
   output logic [NRD*XLEN-1:0]                  rd_data,
   output logic [NRD-1:0]                       rd_busy,
   input  logic [NWR-1:0]                       wr_en,
   input  logic [NWR*$clog2(NREGS)-1:0]         wr_addr,
   input  logic [NWR*XLEN-1:0]                  wr_data,
   input  logic                                 iss_en,
   input  logic [$clog2(NREGS)-1:0]             iss_addr,
   input  logic                                 clr_req,
   output logic                                 clr_busy
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   rf_state_t        state;
   logic [AW-1:0]    cnt;
   logic             idle;
   logic             wr_ok;
   logic [NRD-1:0]   hit;

   assign idle     = (state == RF_IDLE);
   // A clear request in the same cycle drops the writes, so bypass must not forward them
   assign wr_ok    = idle && !clr_req;
   assign clr_busy = (state == RF_CLEAR);

   // Clear engine: walks cnt across every register once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            RF_IDLE: begin
               if (clr_req) begin
                  state <= RF_CLEAR;
                  cnt   <= '0;
               end
            end
            RF_CLEAR: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(NREGS - 1)) state <= RF_IDLE;
            end
            default: state <= RF_IDLE;
         endcase
      end
   end

   // Register array: port writes in IDLE, one register zeroed per cycle in CLEAR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NREGS); k++) regs[k] <= '0;
      end else if (state == RF_CLEAR) begin
         regs[cnt] <= '0;
      end else if (wr_ok) begin
         for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0)))
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard next state: writes retire producers, issue applied last so it wins
   always_comb begin
      busy_nxt = busy;
      if (!idle || clr_req) begin
         busy_nxt = '0;
      end else begin
         for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
         end
         if (iss_en) busy_nxt[iss_addr] = 1'b1;
      end
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   for (genvar gi = 0; gi < int'(NRD); gi++) begin : g_rd
      rf_read_port #(
         .XLEN    (XLEN),
         .NREGS   (NREGS),
         .NWR     (NWR),
         .ZERO_REG(ZERO_REG),
         .AW      (AW)
      ) u_rd (
         .addr   (rd_addr[gi*AW +: AW]),
         .regs   (regs),
         .wr_en  (wr_en),
         .wr_addr(wr_addr),
         .wr_data(wr_data),
         .byp_en (wr_ok),
         .data   (rd_data[gi*XLEN +: XLEN]),
         .hit    (hit[gi])
      );

      assign rd_busy[gi] = idle && busy[rd_addr[gi*AW +: AW]] && !hit[gi];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp against a behavioural register-file model.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                 clk;
   logic                 rst_n;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic [NWR-1:0]       wr_en;
   logic [NWR*AW-1:0]    wr_addr;
   logic [NWR*XLEN-1:0]  wr_data;
   logic                 iss_en;
   logic [AW-1:0]        iss_addr;
   logic                 clr_req;
   logic                 clr_busy;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NRD*XLEN-1:0] d;
      logic [NRD-1:0]      b;
      logic                cb;
   } exp_t;

   exp_t q[$];

   // Reference model state
   logic [XLEN-1:0] mregs [NREGS];
   bit              mbusy [NREGS];
   int              clr_left;

   int checks = 0;
   int errors = 0;
   int hi_cnt;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NREGS; k++) begin
         mregs[k] = '0;
         mbusy[k] = 1'b0;
      end
      clr_left = 0;
   endfunction

   // Expected outputs for the inputs currently applied
   function automatic exp_t predict();
      exp_t e;
      e = '0;
      e.cb = (clr_left > 0);
      for (int i = 0; i < NRD; i++) begin
         int a;
         logic [XLEN-1:0] d;
         bit h;
         a = int'(rd_addr[i*AW +: AW]);
         h = 1'b0;
         if (clr_left > 0) begin
            d = mregs[a];
         end else begin
            d = (a == 0) ? '0 : mregs[a];
            if (!clr_req && a != 0)
               for (int j = 0; j < NWR; j++)
                  if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                     d = wr_data[j*XLEN +: XLEN];
                     h = 1'b1;
                  end
            e.b[i] = mbusy[a] && !h;
         end
         e.d[i*XLEN +: XLEN] = d;
      end
      return e;
   endfunction

   // Advance the model across one clock edge
   function automatic void model_update();
      if (!rst_n) begin
         model_reset();
      end else if (clr_left > 0) begin
         mregs[NREGS - clr_left] = '0;
         clr_left--;
      end else if (clr_req) begin
         clr_left = NREGS;
         for (int k = 0; k < NREGS; k++) mbusy[k] = 1'b0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            int a;
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j]) begin
               if (a != 0) mregs[a] = wr_data[j*XLEN +: XLEN];
               mbusy[a] = 1'b0;
            end
         end
         if (iss_en && iss_addr != '0) mbusy[int'(iss_addr)] = 1'b1;
      end
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
      wr_en   = '0;
      iss_en  = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic step();
      if (!rst_n) model_reset();
      q.push_back(predict());
      model_update();
   endtask

   task automatic cyc(input logic [1:0] wen, input int wa0, input logic [31:0] wd0,
                      input int wa1, input logic [31:0] wd1, input int ra0, input int ra1,
                      input bit iss, input int ia, input bit clr);
      next();
      wr_en    = wen;
      wr_addr  = {AW'(wa1), AW'(wa0)};
      wr_data  = {wd1, wd0};
      rd_addr  = {AW'(ra1), AW'(ra0)};
      iss_en   = iss;
      iss_addr = AW'(ia);
      clr_req  = clr;
      step();
   endtask

   task automatic rd(input int ra0, input int ra1);
      cyc(2'b00, 0, 0, 0, 0, ra0, ra1, 1'b0, 0, 1'b0);
   endtask

   // Monitor: compare every presented cycle against the queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         for (int i = 0; i < NRD; i++)
            chk($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'(e.d[i*XLEN +: XLEN]));
         chk("rd_busy", 64'(rd_busy), 64'(e.b));
         chk("clr_busy", 64'(clr_busy), 64'(e.cb));
      end
   end

   initial begin
      rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
      model_reset();
      next(); step();
      next(); rst_n = 1'b1; step();

      // Reset state on every address
      for (int a = 0; a < NREGS; a++) rd(a, NREGS - 1 - a);
      #1 chk("reset_clr_busy", 64'(clr_busy), 64'd0);

      // Same-cycle bypass then stored value
      cyc(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1'b0, 0, 1'b0);
      #1 chk("bypass_5", 64'(rd_data[31:0]), 64'hDEADBEEF);
      rd(5, 5);
      #1 chk("stored_5", 64'(rd_data[63:32]), 64'hDEADBEEF);

      // Two ports on one register: port 1 wins
      cyc(2'b11, 7, 32'h11, 7, 32'h22, 7, 7, 1'b0, 0, 1'b0);
      #1 chk("bypass_7", 64'(rd_data[31:0]), 64'h22);
      rd(7, 0);
      #1 chk("stored_7", 64'(rd_data[31:0]), 64'h22);

      // Register 0 is hardwired and never busy
      cyc(2'b01, 0, 32'h1234, 0, 0, 0, 0, 1'b0, 0, 1'b0);
      #1 chk("zero_bypass", 64'(rd_data[31:0]), 64'd0);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);
      rd(0, 0);
      #1 chk("zero_busy", 64'(rd_busy), 64'd0);

      // Scoreboard set, clear, and set-wins
      cyc(2'b00, 0, 0, 0, 0, 3, 3, 1'b1, 3, 1'b0);
      rd(3, 0);
      #1 chk("busy_set", 64'(rd_busy[0]), 64'd1);
      cyc(2'b01, 3, 32'h55, 0, 0, 3, 0, 1'b0, 0, 1'b0);
      #1 chk("busy_hit", 64'(rd_busy[0]), 64'd0);
      cyc(2'b01, 3, 32'h66, 0, 0, 0, 0, 1'b1, 3, 1'b0);
      rd(3, 0);
      #1 chk("busy_setwins", 64'(rd_busy[0]), 64'd1);

      // Full clear sequence with a dropped write mid-clear
      for (int r = 1; r < NREGS; r++) cyc(2'b01, r, 32'(r), 0, 0, r, 0, 1'b0, 0, 1'b0);
      cyc(2'b01, 9, 32'hABCD, 0, 0, 9, 0, 1'b0, 0, 1'b1);
      #1 chk("clr_drop_byp", 64'(rd_data[31:0]), 64'd9);
      hi_cnt = 0;
      for (int k = 0; k < NREGS + 6; k++) begin
         if (k == 20) begin
            cyc(2'b01, 1, 32'hBAD, 0, 0, 1, 0, 1'b1, 1, 1'b0);
            #1 chk("clr_no_byp", 64'(rd_data[31:0]), 64'd0);
         end else begin
            rd(k % NREGS, 31);
            #1;
         end
         if (clr_busy) hi_cnt++;
      end
      chk("clr_len", 64'(hi_cnt), 64'(NREGS));
      for (int a = 0; a < NREGS; a++) begin
         rd(a, a);
         #1 chk("clr_zero", 64'(rd_data), 64'd0);
      end

      // Reset in the middle of a clear
      for (int r = 1; r < NREGS; r++) cyc(2'b01, r, 32'(r * 3), 0, 0, r, 0, 1'b0, 0, 1'b0);
      cyc(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b1);
      for (int k = 0; k < 10; k++) rd(31, 30);
      next(); rst_n = 1'b0; step();
      #1 chk("rst_mid_clr", 64'(clr_busy), 64'd0);
      next(); rst_n = 1'b1; step();
      for (int a = 0; a < NREGS; a++) begin
         rd(a, NREGS - 1 - a);
         #1 chk("rst_zero", 64'(rd_data), 64'd0);
      end

      // Randomized traffic, reads biased toward recently written addresses
      for (int n = 0; n < 1500; n++) begin
         int wa0, wa1, ra0, ra1;
         wa0 = $urandom_range(0, NREGS - 1);
         wa1 = ($urandom_range(0, 3) == 0) ? wa0 : $urandom_range(0, NREGS - 1);
         ra0 = ($urandom_range(0, 2) == 0) ? wa1 : $urandom_range(0, NREGS - 1);
         ra1 = ($urandom_range(0, 2) == 0) ? wa0 : $urandom_range(0, NREGS - 1);
         cyc(2'($urandom), wa0, $urandom, wa1, $urandom, ra0, ra1,
             ($urandom_range(0, 2) == 0), $urandom_range(0, NREGS - 1),
             ($urandom_range(0, 149) == 0));
      end

      repeat (2) @(negedge clk);
      chk("queue_drain", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
